// File: rtl/cpu_isa_pkg.sv
// Opcodes of the single-cycle CPU ISA plus the program-loader state and error types.
// Shared by the loader and the control unit so both agree on what is legal.
package cpu_isa_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StVerify,
        StDone,
        StError
    } load_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;
    localparam logic [1:0] ERR_LENGTH   = 2'b11;

endpackage

// File: rtl/op_legal_check.sv
// Combinational opcode legality check; also usable by the CPU for illegal-instruction traps.
module op_legal_check
    import cpu_isa_pkg::*;
(
    input  logic [5:0] op_i,
    output logic       legal_o
);

    always_comb begin
        legal_o = 1'b0;
        case (op_i)
            OP_ADD, OP_ADDI, OP_SUB, OP_ORI, OP_AND, OP_OR,
            OP_MOVE, OP_SW, OP_LW, OP_BEQ, OP_HALT: legal_o = 1'b1;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Assembles big-endian instruction words from a host byte stream, writes them to instruction
// memory, verifies the image by read-back checksum and holds the CPU until the load succeeds.
module prog_loader
    import cpu_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-2:0] len_words_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [WORD_W-1:0] im_wdata_o,
    output logic              im_we_o,
    input  logic [WORD_W-1:0] im_rdata_i,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int unsigned IdxW  = ADDR_W - 2;
    localparam int unsigned LenW  = ADDR_W - 1;
    localparam int unsigned Words = 2 ** IdxW;

    load_state_e       state_q, state_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] wsum_q, wsum_d;
    logic [WORD_W-1:0] rsum_q, rsum_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [WORD_W-1:0] word_asm;
    logic [LenW-1:0]   idx_next;
    logic              op_legal;

    // Three held bytes plus the byte on the bus form the complete word on the 4th transfer.
    assign word_asm = {word_q[WORD_W-9:0], byte_i};
    assign idx_next = {1'b0, idx_q} + LenW'(1);

    op_legal_check u_op_legal_check (
        .op_i    (word_asm[WORD_W-1:WORD_W-6]),
        .legal_o (op_legal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            wsum_q     <= wsum_d;
            rsum_q     <= rsum_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        wsum_d     = wsum_q;
        rsum_d     = rsum_q;
        err_code_d = err_code_q;
        case (state_q)
            // DONE and ERROR restart exactly like IDLE.
            StIdle, StDone, StError: begin
                if (start_i) begin
                    len_d      = len_words_i;
                    idx_d      = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    wsum_d     = '0;
                    rsum_d     = '0;
                    err_code_d = ERR_NONE;
                    if (len_words_i == '0) begin
                        state_d = StDone;
                    end else if (len_words_i > LenW'(Words)) begin
                        state_d    = StError;
                        err_code_d = ERR_LENGTH;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                if (byte_valid_i) begin
                    word_d     = word_asm;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (op_legal) begin
                            state_d = StWrite;
                        end else begin
                            state_d    = StError;
                            err_code_d = ERR_ILLEGAL;
                        end
                    end
                end
            end
            StWrite: begin
                wsum_d = wsum_q + word_q;
                if (idx_next == len_q) begin
                    state_d = StVerify;
                    idx_d   = '0;
                end else begin
                    state_d    = StRecv;
                    idx_d      = idx_q + IdxW'(1);
                    byte_cnt_d = '0;
                end
            end
            StVerify: begin
                rsum_d = rsum_q + im_rdata_i;
                idx_d  = idx_q + IdxW'(1);
                if (idx_next == len_q) begin
                    if (rsum_d == wsum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StError;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_ready_o = 1'b0;
        im_we_o      = 1'b0;
        im_addr_o    = '0;
        im_wdata_o   = '0;
        cpu_hold_o   = 1'b1;
        done_o       = 1'b0;
        err_o        = 1'b0;
        err_code_o   = err_code_q;
        case (state_q)
            StRecv:   byte_ready_o = 1'b1;
            StWrite: begin
                im_we_o    = 1'b1;
                im_addr_o  = {idx_q, 2'b00};
                im_wdata_o = word_q;
            end
            StVerify: im_addr_o = {idx_q, 2'b00};
            StDone: begin
                done_o     = 1'b1;
                cpu_hold_o = 1'b0;
            end
            StError:  err_o = 1'b1;
            default: ;
        endcase
    end

endmodule
